// File: rtl/rr_unpack_pkg.sv
// Shared types and elaboration helpers for the logging-bus unpacker.
package rr_unpack_pkg;

    localparam int unsigned RR_CHANNEL_WIDTH_BITS = 16;
    localparam int unsigned RR_MAX_CHANNELS       = 16;
    localparam int unsigned RR_IDX_W              = $clog2(RR_MAX_CHANNELS);

    typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_chan_widths_t;

    function automatic int unsigned WIDTH_UNITS(input int unsigned w, input int unsigned pa);
        return w / pa;
    endfunction

    // Fixed unpacked slot offset of channel idx: sum of all lower channel widths.
    function automatic int unsigned GET_SLOT_OFFSET(input rr_chan_widths_t widths, input int unsigned idx);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < RR_MAX_CHANNELS; i++) begin
            if (i < idx) begin
                off = off + 32'(widths[RR_IDX_W'(i)]);
            end
        end
        return off;
    endfunction

endpackage

// File: rtl/rr_elastic_stage.sv
// One elastic valid/ready register slice; holds its contents while downstream stalls.
module rr_elastic_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Accept when empty or when the current occupant leaves this cycle.
    assign o_ready = rstn && (!r_valid || i_ready);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (o_ready) begin
                r_valid <= i_valid;
            end
            if (o_ready && i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/rr_logging_bus_pack2unpack.sv
// Scatters a densely packed logb beat back to fixed per-channel slots (2-stage elastic pipe).
// Optional length checker enabled by defining RR_UNPACK_LEN_CHECK_EN.
module rr_logging_bus_pack2unpack
    import rr_unpack_pkg::*;
#(
    parameter int unsigned CHANNEL_CNT = 4,
    // Index 0 is the rightmost entry: widths are 32,64,32,128 for channels 0..3.
    parameter logic [CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {16'd128, 16'd32, 16'd64, 16'd32},
    parameter int unsigned PACKET_ALIGNMENT = 32,
    parameter int unsigned FULL_WIDTH = GET_SLOT_OFFSET(rr_chan_widths_t'(CHANNEL_WIDTHS), CHANNEL_CNT),
    parameter int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHANNEL_CNT-1:0]  in_bitmap,
    input  logic [OFFSET_WIDTH-1:0] in_len,
    input  logic [FULL_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHANNEL_CNT-1:0]  out_bitmap,
    output logic [FULL_WIDTH-1:0]   out_data,
    output logic                    err_sticky
);

    localparam rr_chan_widths_t W_EXT   = rr_chan_widths_t'(CHANNEL_WIDTHS);
    localparam int unsigned     UNITS_W = $clog2(FULL_WIDTH / PACKET_ALIGNMENT + 1);
    localparam int unsigned     S2_W    = CHANNEL_CNT + FULL_WIDTH;

    if (CHANNEL_CNT < 1 || CHANNEL_CNT > RR_MAX_CHANNELS) begin : g_bad_cnt
        $error("rr_logging_bus_pack2unpack: CHANNEL_CNT out of range");
    end
    if (FULL_WIDTH != GET_SLOT_OFFSET(W_EXT, CHANNEL_CNT)) begin : g_bad_full
        $error("rr_logging_bus_pack2unpack: FULL_WIDTH must equal the sum of CHANNEL_WIDTHS");
    end

    logic                   w_s1_ready;
    logic                   w_s1_valid;
    logic [CHANNEL_CNT-1:0] w_s1_bitmap;
    logic [FULL_WIDTH-1:0]  w_s1_data;
    logic                   w_s2_ready;
    logic                   w_s2_load;
    logic [FULL_WIDTH-1:0]  w_unpacked;
    logic [UNITS_W-1:0]     w_sum;

`ifdef RR_UNPACK_LEN_CHECK_EN
    localparam int unsigned S1_W = CHANNEL_CNT + OFFSET_WIDTH + FULL_WIDTH;
    logic [S1_W-1:0]         w_s1_in;
    logic [S1_W-1:0]         w_s1_out;
    logic [OFFSET_WIDTH-1:0] w_s1_len;
    assign w_s1_in = {in_bitmap, in_len, in_data};
    assign {w_s1_bitmap, w_s1_len, w_s1_data} = w_s1_out;
`else
    localparam int unsigned S1_W = CHANNEL_CNT + FULL_WIDTH;
    logic [S1_W-1:0] w_s1_in;
    logic [S1_W-1:0] w_s1_out;
    logic            w_unused_len;
    assign w_s1_in = {in_bitmap, in_data};
    assign {w_s1_bitmap, w_s1_data} = w_s1_out;
    assign w_unused_len = ^{in_len, w_sum};
`endif

    rr_elastic_stage #(.WIDTH(S1_W)) u_s1 (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (in_valid),
        .o_ready (w_s1_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_out)
    );

    assign in_ready  = w_s1_ready;
    assign w_s2_load = w_s1_valid && w_s2_ready;

    // Per channel: running packed offset (in alignment units) and scatter into its fixed slot.
    for (genvar g = 0; g < CHANNEL_CNT; g++) begin : g_ch
        localparam int unsigned CW = 32'(CHANNEL_WIDTHS[g]);
        localparam int unsigned SO = GET_SLOT_OFFSET(W_EXT, g);

        logic [UNITS_W-1:0] w_off;
        logic [UNITS_W-1:0] w_end;

        if (CW % PACKET_ALIGNMENT != 0) begin : g_bad_width
            $error("rr_logging_bus_pack2unpack: channel width not a multiple of PACKET_ALIGNMENT");
        end

        if (g == 0) begin : g_first
            assign w_off = '0;
        end else begin : g_rest
            assign w_off = g_ch[g-1].w_end;
        end

        assign w_end = w_s1_bitmap[g] ? w_off + UNITS_W'(WIDTH_UNITS(CW, PACKET_ALIGNMENT)) : w_off;

        assign w_unpacked[SO +: CW] = w_s1_bitmap[g]
            ? CW'(w_s1_data >> (32'(w_off) * PACKET_ALIGNMENT))
            : '0;
    end

    assign w_sum = g_ch[CHANNEL_CNT-1].w_end;

    rr_elastic_stage #(.WIDTH(S2_W)) u_s2 (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_s1_bitmap, w_unpacked}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  ({out_bitmap, out_data})
    );

`ifdef RR_UNPACK_LEN_CHECK_EN
    logic w_len_bad;
    logic r_err;

    assign w_len_bad = (32'(w_sum) * PACKET_ALIGNMENT) != 32'(w_s1_len);

    // Flag rises together with the offending beat's arrival in S2.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_s2_load && w_len_bad) begin
            r_err <= 1'b1;
`ifndef SYNTHESIS
            $error("rr_unpack len mismatch: bitmap=%b len=%0d expected=%0d",
                   w_s1_bitmap, w_s1_len, 32'(w_sum) * PACKET_ALIGNMENT);
`endif
        end
    end

    assign err_sticky = r_err;
`else
    assign err_sticky = 1'b0;
`endif

endmodule
